// File: rtl/frame_reader.sv
// ---------------------------------------------------------------------------
// frame_reader
//
// Scan-out side of the frame buffer. After the writer reports a complete
// frame (rising edge of frame_rdy), every word of data_mem is read in address
// order 0..MEM_DEPTH-1. The words are presented as a valid/ready pixel stream
// with start-of-frame and end-of-line markers. A 2-entry skid buffer absorbs
// the 1-cycle memory read latency when the consumer applies backpressure.
//
// Optional build macro:
//   FRAME_READER_REPEAT_EN - when defined, a frame whose last pixel is
//                            accepted while frame_rdy is still high restarts
//                            at address 0 on the next cycle without going
//                            through IDLE.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   asynchronous active-low reset
//   frame_rdy  in   writer holds a complete frame (rising edge starts a scan)
//   rd_en      out  memory read enable, active-low
//   rd_addr    out  memory read address
//   rd_data    in   memory read data, valid the cycle after rd_en = 0
//   pix_data   out  stream pixel
//   pix_valid  out  pix_data / pix_sof / pix_eol are valid
//   pix_ready  in   downstream accepts the pixel
//   pix_sof    out  pixel came from address 0
//   pix_eol    out  last pixel of a line
//   frame_done out  one-cycle pulse after the last pixel is accepted
//   busy       out  high from frame start until frame_done
// ---------------------------------------------------------------------------
module frame_reader #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 3,
    parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int LINE_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_rdy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  frame_done,
    output logic                  busy
);

    localparam logic ASSERT   = 1'b0;
    localparam logic DEASSERT = 1'b1;

    // The read counter is one bit wider than the address so that "all reads
    // issued" (count == MEM_DEPTH) is distinguishable from address 0.
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LAST_CNT  = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t state, next_state;

    logic                  frame_rdy_q;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  rf_valid;      // a read is in flight this cycle
    logic [ADDR_WIDTH-1:0] rf_addr;       // address of the in-flight read

    // Skid buffer: two entries, each a pixel plus its markers.
    logic [DATA_WIDTH-1:0] sk_data [2];
    logic [1:0]            sk_sof;
    logic [1:0]            sk_eol;
    logic [1:0]            sk_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;

    logic                  start;
    logic                  issue;
    logic                  pop;
    logic                  last_xfer;
    logic                  finish;
    logic                  restart;
    logic                  rf_is_eol;
    logic [2:0]            pending;

    assign pix_valid = (occ != 2'd0);
    assign pix_data  = sk_data[rd_ptr];
    assign pix_sof   = sk_sof[rd_ptr];
    assign pix_eol   = sk_eol[rd_ptr];
    assign rd_addr   = cnt[ADDR_WIDTH-1:0];

    assign pop       = pix_valid & pix_ready;
    assign last_xfer = pop & sk_last[rd_ptr];
    assign rf_is_eol = ((32'(rf_addr) % LINE_LEN) == (LINE_LEN - 1));

    // Words that will be held once this cycle's edge has completed: the
    // buffered words plus the in-flight read, minus the word popped now.
    // Counting the pop lets a new read issue every cycle under full
    // throughput, while the sum never lets the buffer exceed two entries.
    assign pending = {1'b0, occ} + {2'b0, rf_valid} - {2'b0, pop};

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        next_state = state;
        start      = 1'b0;
        issue      = 1'b0;
        finish     = 1'b0;
        restart    = 1'b0;
        rd_en      = DEASSERT;
        case (state)
            IDLE: begin
                if (frame_rdy && !frame_rdy_q) begin
                    start      = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (cnt < DEPTH_CNT && pending < 3'd2) begin
                    issue = 1'b1;
                    rd_en = ASSERT;
                    if (cnt == LAST_CNT) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    finish = 1'b1;
`ifdef FRAME_READER_REPEAT_EN
                    if (frame_rdy) begin
                        restart    = 1'b1;
                        next_state = STREAM;
                    end else begin
                        next_state = IDLE;
                    end
`else
                    next_state = IDLE;
`endif
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            frame_rdy_q <= 1'b0;
            cnt         <= '0;
            rf_valid    <= 1'b0;
            rf_addr     <= '0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            frame_rdy_q <= frame_rdy;
            if (start || restart) begin
                cnt <= '0;
            end else if (issue) begin
                cnt <= cnt + 1'b1;
            end
            rf_valid <= issue;
            if (issue) begin
                rf_addr <= cnt[ADDR_WIDTH-1:0];
            end
            frame_done <= finish;
            if (start) begin
                busy <= 1'b1;
            end else if (finish && !restart) begin
                busy <= 1'b0;
            end
        end
    end

    // NOTE: the skid entries are reset even though they are storage, because
    // pix_data is driven straight from the head entry and must read 0 after
    // reset; with only two entries this costs almost nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                sk_data[i] <= '0;
            end
            sk_sof  <= '0;
            sk_eol  <= '0;
            sk_last <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= 2'd0;
        end else begin
            // The in-flight read always lands here one cycle after issue.
            if (rf_valid) begin
                sk_data[wr_ptr] <= rd_data;
                sk_sof[wr_ptr]  <= (rf_addr == '0);
                sk_eol[wr_ptr]  <= rf_is_eol;
                sk_last[wr_ptr] <= (rf_addr == LAST_ADDR);
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, rf_valid} - {1'b0, pop};
        end
    end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Scan-out side of the frame buffer.
- After the writer signals that a complete frame is in `data_mem`, this block reads every word in address order from 0 to MEM_DEPTH-1.
- It presents the words as a pixel stream with a valid/ready handshake, plus start-of-frame and end-of-line markers.
- A 2-entry skid buffer absorbs the 1-cycle memory read latency under downstream backpressure.

Parameters:
- DATA_WIDTH, 24, pixel/word width.
- ADDR_WIDTH, 3, memory address width.
- MEM_DEPTH, 1 << ADDR_WIDTH, words per frame.
- LINE_LEN, 4, pixels per line. Must divide MEM_DEPTH and be at least 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- frame_rdy  input  1  high while the writer holds a complete frame. The block samples its rising edge.
- rd_en  output  1  memory read enable, active-low (`ASSERT` = 1'b0), matching `data_mem`.
- rd_addr  output  ADDR_WIDTH  memory read address.
- rd_data  input  DATA_WIDTH  memory read data, valid the cycle after rd_en is asserted.
- pix_data  output  DATA_WIDTH  stream pixel.
- pix_valid  output  1  active-high; pix_data and markers are valid.
- pix_ready  input  1  active-high downstream accept.
- pix_sof  output  1  qualifies the pixel from address 0.
- pix_eol  output  1  qualifies the last pixel of each line.
- frame_done  output  1  one-cycle pulse after the last pixel is accepted.
- busy  output  1  high from frame start until frame_done.

Behaviour:
- Reset (asynchronous, reset = 0): clears state and outputs.
  - rd_en = 1 (deasserted), rd_addr = 0.
  - pix_valid = pix_sof = pix_eol = frame_done = busy = 0, pix_data = 0.
  - Skid buffer emptied; in-flight read discarded; frame_rdy edge detector cleared.
- Transfer rule: a pixel transfers on a clock edge where pix_valid = 1 and pix_ready = 1.
- Stream stability: while pix_valid = 1 and pix_ready = 0, pix_data, pix_sof and pix_eol hold stable.
- State IDLE:
  - Waits for a frame_rdy rising edge (registered previous value; 0→1).
  - On the edge: go to STREAM; busy = 1; read counter = 0.
  - A frame_rdy that is already high out of reset counts as an edge.
- State STREAM:
  - Read issue: issue a read (rd_en = 0, rd_addr = counter) when (buffer occupancy + in-flight reads) < 2 and counter < MEM_DEPTH.
  - Counter then increments.
  - rd_data is captured into the skid buffer the next cycle, tagged with sof (addr == 0) and eol (addr % LINE_LEN == LINE_LEN-1).
  - Once all MEM_DEPTH reads are issued, go to DRAIN.
- State DRAIN:
  - No further reads; rd_en = 1.
  - When the transfer of the last pixel (addr MEM_DEPTH-1) occurs:
    - frame_done pulses the next cycle;
    - busy drops on that same cycle;
    - return to IDLE.
- Latency with pix_ready held at 1:
  - first pix_valid two cycles after the frame_rdy edge;
  - then one pixel per cycle with no bubbles.
- Skid buffer:
  - Output is taken from the head entry.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Occupancy never exceeds 2; overflow is impossible by the issue rule.
- Address wrap: the counter is ADDR_WIDTH+1 bits so reaching MEM_DEPTH is detectable. rd_addr uses the low ADDR_WIDTH bits.
- frame_rdy activity while busy is ignored; no queuing of a second request.
- frame_rdy falling mid-frame does not abort the frame.
- Reset mid-frame: immediate return to IDLE with outputs at their reset values. The partial frame is not resumed.
- pix_ready = 0 indefinitely: reads stall with at most 2 buffered words; no data is lost or duplicated.

Optional Feature:
- Macro: FRAME_READER_REPEAT_EN.
- When defined: after the last pixel transfer, the block restarts at address 0 the next cycle, without passing through IDLE, as long as frame_rdy is still 1.
  - frame_done still pulses once per frame.
  - busy stays 1 across frames.
  - If frame_rdy is 0 at frame end, the block returns to IDLE.
- When undefined: the block always returns to IDLE and requires a new frame_rdy rising edge.

Test Plan:
- Basic scan-out:
  - Setup: ADDR_WIDTH = 3, LINE_LEN = 4; memory word i = 24'hA00000 + i; pix_ready = 1; pulse frame_rdy.
  - Required response: 8 consecutive pixels A00000..A00007; pix_sof only on A00000; pix_eol on A00003 and A00007; one frame_done pulse; busy high for exactly 10 cycles.
- Backpressure:
  - Stimulus: pix_ready toggles 1,0,0,1,... per cycle.
  - Required response: the same 8 values in order with no loss or duplication; at most 2 outstanding reads/buffered words.
  - Required response: while stalled, pix_data is unchanged.
- Reset mid-frame:
  - Stimulus: assert reset after the third pixel transfer.
  - Required response: pix_valid = 0 and rd_en = 1 immediately (asynchronously).
  - Follow-up: after release, a new frame_rdy edge yields the full sequence starting at A00000.
- Ignored request:
  - Stimulus: a second frame_rdy edge mid-frame.
  - Required response: exactly one frame is output; the block then returns to IDLE.
- Repeat mode (FRAME_READER_REPEAT_EN defined):
  - Stimulus: frame_rdy held at 1.
  - Required response: A00007 is followed immediately by A00000 with pix_sof = 1; frame_done pulses each frame.
  - Follow-up: drop frame_rdy mid-frame; the current frame completes, then the block returns to IDLE.
